muldiv_unit: RTL and testbench

- Iterative RV32M/RV64M multiply/divide unit beside the single-cycle integer ALU in the execute stage.
- Takes operands plus an M-extension funct3 code through a valid/ready handshake and computes one result bit per cycle.
- Returns the result through a second valid/ready handshake.
- A flush input lets the pipeline kill an in-flight operation on a branch or trap.

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Request/response bundle for the multiply/divide unit: request handshake, result handshake, flush and busy.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic            busy;

    modport master (
        output flush, in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M mul/div, one result bit per cycle: XLEN+1 cycles, 1 for divide special cases (and multiplies with MULDIV_FAST_MUL_EN).
// Result is held in DONE until out_ready; in_ready is low whenever the unit is not IDLE.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave io
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    state_t            state;
    logic [2:0]        op;
    logic              neg_res;
    logic              neg_rem;
    logic [XLEN-1:0]   b_mag;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   rem;
    logic [CNT_W-1:0]  cnt;
    logic              out_valid_r;
    logic [XLEN-1:0]   out_data_r;

    logic              a_sgn, b_sgn, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag_in, special_res;

    always_comb begin
        a_sgn    = (io.in_op == OP_MULH) || (io.in_op == OP_MULHSU) ||
                   (io.in_op == OP_DIV)  || (io.in_op == OP_REM);
        b_sgn    = (io.in_op == OP_MULH) || (io.in_op == OP_DIV) || (io.in_op == OP_REM);
        sa       = a_sgn & io.in_a[XLEN-1];
        sb       = b_sgn & io.in_b[XLEN-1];
        a_mag    = sa ? -io.in_a : io.in_a;
        b_mag_in = sb ? -io.in_b : io.in_b;
        div_zero = io.in_op[2] && (io.in_b == '0);
        div_ovf  = ((io.in_op == OP_DIV) || (io.in_op == OP_REM)) &&
                   (io.in_a == {1'b1, {(XLEN-1){1'b0}}}) && (io.in_b == '1);
        // op[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero) special_res = io.in_op[1] ? io.in_a : '1;
        else          special_res = io.in_op[1] ? '0 : io.in_a;
    end

    logic              fast_hit;
    logic [XLEN-1:0]   fast_res;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_p, fast_fix;
    always_comb begin
        fast_p   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag_in};
        fast_fix = (sa ^ sb) ? -fast_p : fast_p;
        fast_res = (io.in_op == OP_MUL) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
        fast_hit = !io.in_op[2];
    end
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    // One iteration step; both algorithms start from prod = {0, |a|}
    logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
    logic [2*XLEN-1:0] mul_next, prod_fix;
    logic [XLEN-1:0]   div_rem, div_q, q_fix, r_fix, iter_res;

    always_comb begin
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, b_mag} : '0);
        mul_next = {mul_sum, prod[XLEN-1:1]};
        rem_sh   = {rem, prod[XLEN-1]};
        rem_diff = rem_sh - {1'b0, b_mag};
        div_rem  = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
        div_q    = {prod[XLEN-2:0], ~rem_diff[XLEN]};
        prod_fix = neg_res ? -mul_next : mul_next;
        q_fix    = neg_res ? -div_q : div_q;
        r_fix    = neg_rem ? -div_rem : div_rem;
        if (op[2])              iter_res = op[1] ? r_fix : q_fix;
        else if (op == OP_MUL)  iter_res = prod_fix[XLEN-1:0];
        else                    iter_res = prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            op          <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            b_mag       <= '0;
            prod        <= '0;
            rem         <= '0;
            cnt         <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (io.flush) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (io.in_valid) begin
                    op      <= io.in_op;
                    neg_res <= sa ^ sb;
                    neg_rem <= sa;
                    b_mag   <= b_mag_in;
                    prod    <= {{XLEN{1'b0}}, a_mag};
                    rem     <= '0;
                    cnt     <= '0;
                    if (div_zero || div_ovf) begin
                        out_data_r  <= special_res;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else if (fast_hit) begin
                        out_data_r  <= fast_res;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (op[2]) begin
                        prod <= {prod[2*XLEN-1:XLEN], div_q};
                        rem  <= div_rem;
                    end else begin
                        prod <= mul_next;
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN-1)) begin
                        out_data_r  <= iter_res;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: if (io.out_ready) begin
                    out_valid_r <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.in_ready  = (state == IDLE);
    assign io.busy      = (state != IDLE);
    assign io.out_valid = out_valid_r;
    assign io.out_data  = out_data_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int          XLEN = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int compared   = 0;
    int mismatched = 0;

    muldiv_if #(.XLEN(XLEN)) io();
    muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .io(io));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        p  = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || ((op == 3'd4 || op == 3'd6) && a == MINV && b == 32'hFFFF_FFFF)))
            return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return XLEN + 1;
    endfunction

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!io.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", io.in_ready, 1);
        io.in_valid = 1'b1;
        io.in_op    = op;
        io.in_a     = a;
        io.in_b     = b;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output bit rdy_seen);
        lat = 1;
        rdy_seen = 1'b0;
        while (!io.out_valid && lat < 100) begin
            if (io.in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take();
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
        int lat;
        bit rdy;
        send(op, a, b);
        wait_out(lat, rdy);
        check({tag, "_data"}, io.out_data, exp);
        check({tag, "_lat"}, lat, exp_lat(op, a, b));
        check({tag, "_inrdy"}, rdy, 0);
        take();
    endtask

    logic [2:0]  d_op [13] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd5, 3'd6, 3'd4, 3'd6, 3'd7, 3'd4};
    logic [31:0] d_a  [13] = '{32'd7, MINV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'hFFFF_FFFF, 32'd5, 32'd5, MINV, MINV, 32'd5, 32'd5};
    logic [31:0] d_b  [13] = '{32'hFFFF_FFFD, MINV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                               32'd16, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] d_e  [13] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                               32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'hFFFF_FFFF, 32'd5, MINV, 32'd0, 32'd5,
                               32'hFFFF_FFFF};

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return MINV;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, outs;
        bit rdy;
        logic [2:0]  op;
        logic [31:0] a, b, held;

        io.flush = 1'b0; io.in_valid = 1'b0; io.in_op = '0;
        io.in_a = '0; io.in_b = '0; io.out_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("rst_in_ready", io.in_ready, 1);
        check("rst_out_valid", io.out_valid, 0);
        check("rst_out_data", io.out_data, 0);
        check("rst_busy", io.busy, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            run(d_op[i], d_a[i], d_b[i], d_e[i], $sformatf("dir%0d", i));

        // Backpressure: result held stable, then same-cycle consume + new request
        send(3'd4, 32'hFFFF_FFF9, 32'd2);
        wait_out(lat, rdy);
        held = io.out_data;
        check("bp_first", held, 32'hFFFF_FFFD);
        io.in_valid = 1'b1; io.in_op = 3'd0; io.in_a = 32'd3; io.in_b = 32'd5;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid", io.out_valid, 1);
            check("bp_data", io.out_data, 32'hFFFF_FFFD);
            check("bp_in_ready", io.in_ready, 0);
        end
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;
        check("cons_out_valid", io.out_valid, 0);
        check("cons_in_ready", io.in_ready, 1);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        check("acc_in_ready", io.in_ready, 0);
        wait_out(lat, rdy);
        check("acc_data", io.out_data, 32'd15);
        check("acc_lat", lat, exp_lat(3'd0, 32'd3, 32'd5));
        take();

        // Flush at iteration 12 of a DIVU
        send(3'd5, 32'd1000, 32'd3);
        repeat (12) @(posedge clk);
        #1 io.flush = 1'b1;
        @(posedge clk); #1;
        io.flush = 1'b0;
        check("flush_busy", io.busy, 0);
        check("flush_in_ready", io.in_ready, 1);
        outs = 0;
        for (int i = 0; i < 40; i++) begin
            if (io.out_valid) outs++;
            @(posedge clk); #1;
        end
        check("flush_no_out", outs, 0);
        io.flush = 1'b1; io.in_valid = 1'b1; io.in_op = 3'd5; io.in_a = 32'd9; io.in_b = 32'd2;
        @(posedge clk); #1;
        io.flush = 1'b0; io.in_valid = 1'b0;
        check("flush_req_drop", io.busy, 0);
        run(3'd0, 32'd3, 32'd4, 32'd12, "mul_after_flush");

        // Reset mid-BUSY
        send(3'd5, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_in_ready", io.in_ready, 1);
        check("mrst_out_valid", io.out_valid, 0);
        check("mrst_out_data", io.out_data, 0);
        check("mrst_busy", io.busy, 0);
        rst_n = 1'b1;
        run(3'd5, 32'd100, 32'd7, 32'd14, "divu_after_rst");

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run(op, a, b, model(op, a, b), $sformatf("rnd%0d_op%0d", i, op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
